// File: rtl/cat_rec_pkg.sv
// Shared constants and types for the cat recognizer APB front-end:
// register map, STATUS bit positions and the FSM state encodings.
package cat_rec_pkg;

   localparam int CTRL_ADDR   = 0;
   localparam int STATUS_ADDR = 1;
   localparam int INFO_ADDR   = 2;
   localparam int MEM_BASE    = 16;

   localparam int CTRL_START  = 0;
   localparam int ST_BUSY     = 0;
   localparam int ST_DONE     = 1;
   localparam int ST_RESULT   = 2;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
   typedef enum logic       {C_IDLE, C_BUSY}      core_state_e;

   typedef enum logic [2:0] {
      REG_CTRL,
      REG_STATUS,
      REG_INFO,
      REG_RSVD,
      REG_MEM
   } region_e;

endpackage

// File: rtl/cat_rec_apb_ctrl_if.sv
// APB3 completer-side bus bundle for the cat recognizer front-end.
interface cat_rec_apb_ctrl_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 24
);
   logic [ADDR_W-1:0] PADDR;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/cat_rec_apb_decode.sv
// Combinational APB address decode: region, interleaved bank/row and the
// error flag for the transfer currently on the bus.
module cat_rec_apb_decode
   import cat_rec_pkg::*;
#(
   parameter int Amba_Addr_Depth = 13,
   parameter int Num_Banks       = 4,
   parameter int Bank_Depth      = 1024,
   parameter int BANK_W          = 2,
   parameter int ROW_W           = 10
) (
   input  logic [Amba_Addr_Depth-1:0] paddr_i,
   input  logic                       pwrite_i,
   input  logic                       start_bit_i,
   input  logic                       busy_i,
   output region_e                    region_o,
   output logic [BANK_W-1:0]          bank_o,
   output logic [ROW_W-1:0]           row_o,
   output logic                       err_o
);

   localparam logic [31:0] MEM_WORDS = 32'(Num_Banks * Bank_Depth);
   localparam int          BANK_SH   = $clog2(Num_Banks);

   logic [31:0] addr_w;
   logic [31:0] off_w;

   // NOTE: every output gets a default before the branches, otherwise an
   // incomplete assignment infers a latch.
   always_comb begin
      addr_w   = 32'(paddr_i);
      off_w    = addr_w - 32'(MEM_BASE);
      bank_o   = BANK_W'(off_w & 32'(Num_Banks - 1));
      row_o    = ROW_W'(off_w >> BANK_SH);
      region_o = REG_RSVD;
      err_o    = 1'b1;

      if (addr_w == 32'(CTRL_ADDR)) begin
         region_o = REG_CTRL;
         err_o    = pwrite_i & start_bit_i & busy_i;
      end else if (addr_w == 32'(STATUS_ADDR)) begin
         region_o = REG_STATUS;
         err_o    = 1'b0;
      end else if (addr_w == 32'(INFO_ADDR)) begin
         region_o = REG_INFO;
         err_o    = pwrite_i;
      end else if (addr_w >= 32'(MEM_BASE)) begin
         // The memory window is write-only and locked while the core runs.
         region_o = REG_MEM;
         err_o    = ~pwrite_i | busy_i | (off_w >= MEM_WORDS);
      end
   end

endmodule

// File: rtl/cat_rec_apb_ctrl.sv
// APB3 front-end for the cat recognizer: control/status registers, banked
// memory write port and the core start/done sequencer.
module cat_rec_apb_ctrl
   import cat_rec_pkg::*;
#(
   parameter int Amba_Word       = 24,
   parameter int Amba_Addr_Depth = 13,
   parameter int Num_Banks       = 4,
   parameter int Bank_Depth      = 1024,
   parameter int Wait_States     = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   cat_rec_apb_ctrl_if.slave             apb,
   output logic [Num_Banks-1:0]          mem_we,
   output logic [$clog2(Bank_Depth)-1:0] mem_addr,
   output logic [Amba_Word-1:0]          mem_wdata,
   output logic                          core_start,
   input  logic                          core_done,
   input  logic                          core_result,
   output logic                          CatRecOut
);

   localparam int BANK_W = (Num_Banks > 1) ? $clog2(Num_Banks) : 1;
   localparam int ROW_W  = $clog2(Bank_Depth);
   localparam logic [31:0] INFO_VAL = {16'd0, 8'(ROW_W), 8'(Num_Banks)};

   apb_state_e               apb_state_q;
   logic [1:0]               wait_q;
   logic                     pready_q;
   core_state_e              core_state_q;
   logic                     core_start_q;
   logic                     done_q;
   logic                     result_q;
   logic [Num_Banks-1:0]     mem_we_q;
   logic [ROW_W-1:0]         mem_addr_q;
   logic [Amba_Word-1:0]     mem_wdata_q;

   region_e                  region;
   logic [BANK_W-1:0]        bank;
   logic [ROW_W-1:0]         row;
   logic                     dec_err;
   logic                     busy;
   logic                     commit;
   logic                     wr_ok;
   logic                     start_cmt;
   logic                     clear_cmt;
   logic                     mem_cmt;
   logic [Amba_Word-1:0]     rdata_d;

   assign busy = (core_state_q == C_BUSY);

   cat_rec_apb_decode #(
      .Amba_Addr_Depth (Amba_Addr_Depth),
      .Num_Banks       (Num_Banks),
      .Bank_Depth      (Bank_Depth),
      .BANK_W          (BANK_W),
      .ROW_W           (ROW_W)
   ) u_decode (
      .paddr_i     (apb.PADDR),
      .pwrite_i    (apb.PWRITE),
      .start_bit_i (apb.PWDATA[CTRL_START]),
      .busy_i      (busy),
      .region_o    (region),
      .bank_o      (bank),
      .row_o       (row),
      .err_o       (dec_err)
   );

   assign commit    = (apb_state_q == ACCESS) & pready_q & apb.PSEL & apb.PENABLE;
   assign wr_ok     = commit & apb.PWRITE & ~dec_err;
   assign start_cmt = wr_ok & (region == REG_CTRL)   & apb.PWDATA[CTRL_START];
   assign clear_cmt = wr_ok & (region == REG_STATUS) & apb.PWDATA[ST_DONE];
   assign mem_cmt   = wr_ok & (region == REG_MEM);

   always_comb begin
      rdata_d = '0;
      case (region)
         REG_STATUS: begin
            rdata_d[ST_BUSY]   = busy;
            rdata_d[ST_DONE]   = done_q;
            rdata_d[ST_RESULT] = result_q;
         end
         REG_INFO: rdata_d = Amba_Word'(INFO_VAL);
         default:  rdata_d = '0;
      endcase
   end

   // Error and read data are only driven during the ready cycle, so both
   // read as zero whenever PREADY is low.
   assign apb.PREADY  = pready_q;
   assign apb.PSLVERR = pready_q & dec_err;
   assign apb.PRDATA  = (pready_q & ~apb.PWRITE & ~dec_err) ? rdata_d : '0;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values and updates together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         apb_state_q <= IDLE;
         wait_q      <= '0;
         pready_q    <= 1'b0;
      end else begin
         case (apb_state_q)
            IDLE: begin
               if (apb.PSEL & ~apb.PENABLE) apb_state_q <= SETUP;
            end
            SETUP: begin
               if (!apb.PSEL) begin
                  apb_state_q <= IDLE;
               end else if (apb.PENABLE) begin
                  apb_state_q <= ACCESS;
                  wait_q      <= '0;
                  pready_q    <= (Wait_States == 0);
               end
            end
            ACCESS: begin
               if (pready_q) begin
                  pready_q    <= 1'b0;
                  apb_state_q <= apb.PSEL ? SETUP : IDLE;
               end else if (!apb.PSEL) begin
                  apb_state_q <= IDLE;
                  wait_q      <= '0;
               end else if (wait_q == 2'(Wait_States - 1)) begin
                  pready_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + 2'd1;
               end
            end
            default: apb_state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_state_q <= C_IDLE;
         core_start_q <= 1'b0;
         done_q       <= 1'b0;
         result_q     <= 1'b0;
      end else begin
         core_start_q <= 1'b0;
         if (clear_cmt) done_q <= 1'b0;
         // A completion in the same cycle as a done-clear overrides the clear.
         case (core_state_q)
            C_IDLE: begin
               if (start_cmt) begin
                  core_state_q <= C_BUSY;
                  core_start_q <= 1'b1;
                  done_q       <= 1'b0;
               end
            end
            C_BUSY: begin
               if (core_done) begin
                  core_state_q <= C_IDLE;
                  done_q       <= 1'b1;
                  result_q     <= core_result;
               end
            end
            default: core_state_q <= C_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_we_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         mem_we_q    <= mem_cmt ? (Num_Banks'(1) << bank) : '0;
         mem_addr_q  <= mem_cmt ? row : '0;
         mem_wdata_q <= mem_cmt ? apb.PWDATA : '0;
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign core_start = core_start_q;
   assign CatRecOut  = result_q;

endmodule

// File: tb/tb_cat_rec_apb_ctrl.sv
// Directed bench for cat_rec_apb_ctrl with a transaction-level reference
// model and a per-cycle output comparator.
`timescale 1ns/1ps
module tb_cat_rec_apb_ctrl;

   localparam int DW    = 24;
   localparam int AD    = 13;
   localparam int NB    = 4;
   localparam int BD    = 1024;
   localparam int WS    = 2;
   localparam int ROW_W = $clog2(BD);

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic core_done = 1'b0;
   logic core_result = 1'b0;
   logic [NB-1:0]    mem_we;
   logic [ROW_W-1:0] mem_addr;
   logic [DW-1:0]    mem_wdata;
   logic             core_start;
   logic             CatRecOut;

   always #5 clk = ~clk;

   cat_rec_apb_ctrl_if #(.ADDR_W(AD), .DATA_W(DW)) apb_bus ();

   cat_rec_apb_ctrl #(
      .Amba_Word       (DW),
      .Amba_Addr_Depth (AD),
      .Num_Banks       (NB),
      .Bank_Depth      (BD),
      .Wait_States     (WS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .apb         (apb_bus),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .core_start  (core_start),
      .core_done   (core_done),
      .core_result (core_result),
      .CatRecOut   (CatRecOut)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: core status plus effects pending for the next edge.
   bit               m_busy, m_done, m_result, old_busy;
   bit               pend_start, pend_clear, cur_start;
   logic [NB-1:0]    pend_we, cur_we;
   logic [ROW_W-1:0] pend_row, cur_row;
   logic [DW-1:0]    pend_wd, cur_wd;

   task automatic model_commit(input int addr, input bit write, input logic [DW-1:0] wd,
                               output bit err, output logic [DW-1:0] rd);
      int off;
      err = 1'b0;
      rd  = '0;
      if (addr == 0) begin
         if (write && wd[0]) begin
            if (m_busy) err = 1'b1;
            else        pend_start = 1'b1;
         end
      end else if (addr == 1) begin
         if (write) begin
            if (wd[1]) pend_clear = 1'b1;
         end else begin
            rd = DW'({m_result, m_done, m_busy});
         end
      end else if (addr == 2) begin
         if (write) err = 1'b1;
         else       rd  = DW'(ROW_W * 256 + NB);
      end else if (addr < 16) begin
         err = 1'b1;
      end else begin
         off = addr - 16;
         if (!write || m_busy || off >= NB * BD) begin
            err = 1'b1;
         end else begin
            pend_we  = NB'(1) << (off % NB);
            pend_row = ROW_W'(off / NB);
            pend_wd  = wd;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (!rst) begin
            m_busy = 0; m_done = 0; m_result = 0;
            pend_start = 0; pend_clear = 0; cur_start = 0;
            pend_we = '0; cur_we = '0; pend_row = '0; cur_row = '0;
            pend_wd = '0; cur_wd = '0;
         end else begin
            cur_we    = pend_we;
            cur_row   = pend_row;
            cur_wd    = pend_wd;
            cur_start = pend_start;
            old_busy  = m_busy;
            if (pend_start) begin m_busy = 1; m_done = 0; end
            if (pend_clear) m_done = 0;
            if (core_done && old_busy) begin
               m_busy = 0; m_done = 1; m_result = core_result;
            end
            pend_start = 0; pend_clear = 0; pend_we = '0; pend_row = '0; pend_wd = '0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            check("mem_we", 32'(mem_we), 32'(cur_we));
            if (cur_we != '0) begin
               check("mem_addr", 32'(mem_addr), 32'(cur_row));
               check("mem_wdata", 32'(mem_wdata), 32'(cur_wd));
            end
            check("core_start", 32'(core_start), 32'(cur_start));
            check("CatRecOut", 32'(CatRecOut), 32'(m_result));
            if (!apb_bus.PREADY) check("pslverr_idle", 32'(apb_bus.PSLVERR), 32'd0);
            else check("pready_phase", 32'(apb_bus.PSEL && apb_bus.PENABLE), 32'd1);
         end
      end
   end

   task automatic apb_xfer(input int addr, input bit write, input logic [DW-1:0] wdata,
                           input bit rst_at_ready, output logic [DW-1:0] rdata, output logic err);
      int          cnt;
      bit          exp_err;
      logic [DW-1:0] exp_rd;
      @(posedge clk); #1;
      apb_bus.PSEL    = 1'b1;
      apb_bus.PENABLE = 1'b0;
      apb_bus.PADDR   = AD'(addr);
      apb_bus.PWRITE  = write;
      apb_bus.PWDATA  = wdata;
      @(posedge clk); #1;
      apb_bus.PENABLE = 1'b1;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!apb_bus.PREADY && cnt < 20);
      check("pready_latency", 32'(cnt), 32'(WS + 2));
      rdata = apb_bus.PRDATA;
      err   = apb_bus.PSLVERR;
      if (rst_at_ready) begin
         #2 rst = 1'b0;
         #1;
         check("rst_pready", 32'(apb_bus.PREADY), 32'd0);
         check("rst_pslverr", 32'(apb_bus.PSLVERR), 32'd0);
         check("rst_prdata", 32'(apb_bus.PRDATA), 32'd0);
      end else begin
         model_commit(addr, write, wdata, exp_err, exp_rd);
         check("pslverr", 32'(err), 32'(exp_err));
         check("prdata", 32'(rdata), 32'(exp_rd));
      end
      @(posedge clk); #1;
      apb_bus.PSEL    = 1'b0;
      apb_bus.PENABLE = 1'b0;
   endtask

   task automatic pulse_done(input int delay, input bit res);
      repeat (delay) @(posedge clk);
      #1;
      core_done   = 1'b1;
      core_result = res;
      @(posedge clk); #1;
      core_done   = 1'b0;
      core_result = 1'b0;
   endtask

   task automatic hold_reset_and_release();
      repeat (2) begin
         @(negedge clk);
         check("rst_mem_we", 32'(mem_we), 32'd0);
         check("rst_core_start", 32'(core_start), 32'd0);
      end
      @(posedge clk); #1 rst = 1'b1;
   endtask

   logic [DW-1:0] rd;
   logic          er;

   initial begin
      apb_bus.PSEL = 0; apb_bus.PENABLE = 0; apb_bus.PWRITE = 0;
      apb_bus.PADDR = '0; apb_bus.PWDATA = '0;
      repeat (2) @(negedge clk);
      check("reset_pready", 32'(apb_bus.PREADY), 32'd0);
      check("reset_mem_we", 32'(mem_we), 32'd0);
      check("reset_start", 32'(core_start), 32'd0);
      check("reset_catrec", 32'(CatRecOut), 32'd0);
      @(posedge clk); #1 rst = 1'b1;

      apb_xfer(1, 0, '0, 0, rd, er);
      check("status_after_reset", 32'(rd), 32'h0);
      apb_xfer(2, 0, '0, 0, rd, er);
      check("info_literal", 32'(rd), 32'h000A04);

      apb_xfer(16 + 9, 1, 24'hABCDEF, 0, rd, er);
      @(negedge clk);
      check("mem_we_lit", 32'(mem_we), 32'b0010);
      check("mem_addr_lit", 32'(mem_addr), 32'd2);
      check("mem_wdata_lit", 32'(mem_wdata), 32'hABCDEF);
      apb_xfer(16 + 4095, 1, 24'h123456, 0, rd, er);

      apb_xfer(16 + 4096, 1, 24'h111111, 0, rd, er);
      check("oor_err_lit", 32'(er), 32'd1);
      apb_xfer(20, 0, '0, 0, rd, er);
      check("memrd_err_lit", 32'(er), 32'd1);
      check("memrd_data_lit", 32'(rd), 32'd0);
      apb_xfer(5, 0, '0, 0, rd, er);
      apb_xfer(2, 1, 24'hFFFFFF, 0, rd, er);
      check("info_wr_err_lit", 32'(er), 32'd1);

      apb_xfer(0, 1, 24'h1, 0, rd, er);
      apb_xfer(1, 0, '0, 0, rd, er);
      check("status_busy_lit", 32'(rd), 32'h1);
      apb_xfer(0, 1, 24'h1, 0, rd, er);
      check("start_busy_err_lit", 32'(er), 32'd1);
      apb_xfer(16, 1, 24'h0000AA, 0, rd, er);
      check("mem_busy_err_lit", 32'(er), 32'd1);

      pulse_done(1, 1'b1);
      apb_xfer(1, 0, '0, 0, rd, er);
      check("status_done_lit", 32'(rd), 32'h6);
      check("catrec_lit", 32'(CatRecOut), 32'd1);
      apb_xfer(1, 1, 24'h2, 0, rd, er);
      apb_xfer(1, 0, '0, 0, rd, er);
      check("status_cleared_lit", 32'(rd), 32'h4);

      apb_xfer(0, 1, 24'h1, 0, rd, er);
      fork
         apb_xfer(0, 1, 24'h1, 0, rd, er);
         pulse_done(5, 1'b0);
      join
      check("start_vs_done_err_lit", 32'(er), 32'd1);
      apb_xfer(1, 0, '0, 0, rd, er);
      check("status_race_lit", 32'(rd), 32'h2);

      apb_xfer(0, 1, 24'h1, 0, rd, er);
      fork
         apb_xfer(1, 1, 24'h2, 0, rd, er);
         pulse_done(5, 1'b1);
      join
      apb_xfer(1, 0, '0, 0, rd, er);
      check("status_setwins_lit", 32'(rd), 32'h6);

      apb_xfer(0, 1, 24'h0, 0, rd, er);
      pulse_done(1, 1'b0);
      check("idle_done_ignored_lit", 32'(CatRecOut), 32'd1);

      apb_xfer(16 + 3, 1, 24'h00C0DE, 1, rd, er);
      hold_reset_and_release();
      apb_xfer(0, 1, 24'h1, 1, rd, er);
      hold_reset_and_release();
      apb_xfer(0, 1, 24'h1, 0, rd, er);
      @(negedge clk); #2 rst = 1'b0;
      hold_reset_and_release();
      apb_xfer(1, 0, '0, 0, rd, er);
      check("status_after_busy_reset", 32'(rd), 32'h0);
      check("catrec_after_reset", 32'(CatRecOut), 32'd0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cat_rec_apb_ctrl.md
Name: cat_rec_apb_ctrl

Overview:
Next-generation APB front-end for the cat recognizer, generalised in data width, memory depth, bank count and wait states. Decodes APB3 transfers into control/status registers and a banked, interleaved weight/pixel memory write port. Sequences the recognizer core with a start/done handshake and reports the classification result. Sits between the APB bus interface and the core datapath/memories.

Parameters:
Amba_Word, 24, APB data width (bits), >= 8
Amba_Addr_Depth, 13, APB word-address width
Num_Banks, 4, memory banks, power of 2, 1..16
Bank_Depth, 1024, words per bank, power of 2
Wait_States, 0, PREADY-low cycles inserted per ACCESS phase, 0..3

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
PADDR  in  Amba_Addr_Depth  APB word address
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PWDATA  in  Amba_Word  APB write data
PRDATA  out  Amba_Word  APB read data
PREADY  out  1  APB ready
PSLVERR  out  1  APB error, valid with PREADY
mem_we  out  Num_Banks  one-hot bank write enable
mem_addr  out  log2(Bank_Depth)  row address
mem_wdata  out  Amba_Word  memory write data
core_start  out  1  one-cycle core start pulse
core_done  in  1  one-cycle core completion pulse
core_result  in  1  classification bit, valid with core_done
CatRecOut  out  1  latched result

Behaviour:
- Reset (rst=0, async): all outputs 0; FSMs IDLE; busy=done=result=0; wait counter 0.
- APB FSM: IDLE -> SETUP on PSEL&!PENABLE -> ACCESS on PENABLE. ACCESS holds PREADY=0 for Wait_States cycles, then PREADY=1 one cycle; commit on PSEL&PENABLE&PREADY; return to SETUP if PSEL still high, else IDLE. PREADY=0 outside ACCESS.
- Register map (word addr): 0 CTRL (W: bit0=1 start; R: 0); 1 STATUS (R: bit0 busy, bit1 done, bit2 result; W: bit1=1 clears done); 2 INFO (R: Num_Banks in [7:0], log2(Bank_Depth) in [15:8], RO); 3..15 reserved.
- Memory region: addr >= 16. off=PADDR-16; bank=off mod Num_Banks; row=off/Num_Banks. Valid iff off < Num_Banks*Bank_Depth. Write-only.
- Memory write commit: mem_we[bank], mem_addr, mem_wdata asserted exactly one cycle, the cycle after commit (registered); otherwise mem_we=0.
- PSLVERR=1 (with PREADY) and no side effect for: reserved-address access, out-of-range memory offset, any memory read, memory write while busy, start write while busy, write to INFO. PRDATA=0 on errors and on memory/reserved reads.
- Core FSM: IDLE -> BUSY on committed start (not busy): core_start=1 the cycle after commit, done cleared, busy=1. BUSY -> IDLE on core_done: busy=0, done=1, result and CatRecOut <= core_result same edge. core_done in IDLE is ignored.
- Simultaneous core_done and start commit in BUSY: start errors (busy at commit), core_done completes normally.
- Simultaneous done-clear write and core_done: done ends 1 (set wins).
- CatRecOut holds until next core_done or reset; unaffected by start/clear.
- Reset mid-transfer or mid-BUSY: immediate return to reset state; no pending mem_we or core_start issued.

Decomposition:
- Package cat_rec_pkg: address constants (CTRL_ADDR, STATUS_ADDR, INFO_ADDR, MEM_BASE=16), STATUS bit indices, APB state enum (IDLE/SETUP/ACCESS), core state enum (C_IDLE/C_BUSY).
- One sub-module: cat_rec_apb_decode (combinational address decode: region select, bank, row, error flag).

Test Plan:
- Reset mid-ACCESS with Wait_States=2 -> PREADY, PSLVERR, mem_we, core_start all 0 immediately; STATUS read after reset = 0.
- Num_Banks=4, write 0xABCDEF to addr 16+9 -> mem_we=4'b0010, mem_addr=2, mem_wdata=0xABCDEF one cycle after commit; Wait_States=2 gives PREADY exactly 3rd ACCESS cycle.
- Write addr 16+4096 (Bank_Depth=1024) -> PSLVERR=1, mem_we stays 0; read addr 20 -> PRDATA=0, PSLVERR=1.
- Write CTRL=1 -> core_start one pulse, STATUS=0x1; second CTRL=1 -> PSLVERR; memory write while busy -> PSLVERR, no mem_we.
- core_done with core_result=1 -> STATUS=0x6, CatRecOut=1; write STATUS=0x2 -> STATUS=0x4, CatRecOut stays 1.
- Start commit on same edge as core_done -> PSLVERR=1, no core_start, STATUS shows done=1, busy=0.
